// File: rtl/shift_deserializer_if.sv
// Serial receive link plus word-holding handshake between the link driver and the deserializer.
// The master drives the bit stream and the consumer ack; the slave returns the assembled word.
interface shift_deserializer_if #(
  parameter int DATA_WIDTH = 8
);
  localparam int CNT_WIDTH = $clog2(DATA_WIDTH);

  logic                  serial_in;
  logic                  enable;
  logic                  clear;
  logic                  data_ack;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  overrun;
  logic                  busy;
  logic [CNT_WIDTH-1:0]  bit_count;

  modport master (
    output serial_in, enable, clear, data_ack,
    input  data_out, data_valid, overrun, busy, bit_count
  );

  modport slave (
    input  serial_in, enable, clear, data_ack,
    output data_out, data_valid, overrun, busy, bit_count
  );
endinterface

// File: rtl/shift_deserializer.sv
// MSB-first serial-to-parallel receiver; word is valid on the edge sampling its last bit.
// No backpressure on the link: a word completing while the holding register is full is dropped and flagged.
module shift_deserializer #(
  parameter int DATA_WIDTH = 8
) (
  input logic               clk,
  input logic               reset,
  shift_deserializer_if.slave bus
);
  localparam int CNT_WIDTH = $clog2(DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(DATA_WIDTH - 1);

  // Only DATA_WIDTH-1 bits need storing: the final bit goes straight from serial_in into the word.
  logic [DATA_WIDTH-2:0] shift_reg;
  logic [CNT_WIDTH-1:0]  bit_count;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  overrun;

  logic                  shift_en;
  logic                  word_done;
  logic [DATA_WIDTH-1:0] word;

  assign shift_en  = bus.enable && !bus.clear;
  assign word_done = shift_en && (bit_count == LAST_BIT);
  assign word      = {shift_reg, bus.serial_in};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_reg <= '0;
      bit_count <= '0;
    end else if (bus.clear) begin
      shift_reg <= '0;
      bit_count <= '0;
    end else if (word_done) begin
      shift_reg <= '0;
      bit_count <= '0;
    end else if (shift_en) begin
      shift_reg <= word[DATA_WIDTH-2:0];
      bit_count <= bit_count + 1'b1;
    end
  end

  // Handshake path runs independently of clear; completion cannot coincide with clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (word_done) begin
        if (!data_valid || bus.data_ack) begin
          data_out   <= word;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (bus.data_ack) begin
        data_valid <= 1'b0;
      end

      if (bus.clear) begin
        overrun <= 1'b0;
      end
    end
  end

  assign bus.data_out   = data_out;
  assign bus.data_valid = data_valid;
  assign bus.overrun    = overrun;
  assign bus.bit_count  = bit_count;
  assign bus.busy       = (bit_count != '0);
endmodule

// File: tb/tb_shift_deserializer.sv
// Directed and randomized checks of shift_deserializer against a word-level bit-queue model.
module tb_shift_deserializer;
  localparam int W = 8;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  shift_deserializer_if #(.DATA_WIDTH(W)) bus ();

  shift_deserializer #(.DATA_WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: received bits kept as a plain list, word value built arithmetically.
  int         m_bits[$];
  logic [7:0] m_out;
  logic       m_vld;
  logic       m_ovr;

  task automatic model_reset();
    m_bits.delete();
    m_out = 8'h00;
    m_vld = 1'b0;
    m_ovr = 1'b0;
  endtask

  task automatic model_step(input logic en, input logic b, input logic clr, input logic ack);
    int value;
    logic completed;
    completed = 1'b0;
    value = 0;
    if (clr) begin
      m_bits.delete();
      m_ovr = 1'b0;
    end else if (en) begin
      m_bits.push_back(b ? 1 : 0);
      if (m_bits.size() == W) begin
        foreach (m_bits[k]) value = value * 2 + m_bits[k];
        m_bits.delete();
        completed = 1'b1;
      end
    end
    if (completed) begin
      if (!m_vld || ack) begin
        m_out = value[7:0];
        m_vld = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (ack) begin
      m_vld = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".data_out"},   32'(bus.data_out),   32'(m_out));
    chk({tag, ".data_valid"}, 32'(bus.data_valid), 32'(m_vld));
    chk({tag, ".overrun"},    32'(bus.overrun),    32'(m_ovr));
    chk({tag, ".bit_count"},  32'(bus.bit_count),  32'(m_bits.size()));
    chk({tag, ".busy"},       32'(bus.busy),       32'(m_bits.size() != 0));
  endtask

  // Inputs change 1ns after the rising edge; outputs are checked at that same point.
  task automatic cycle(input string tag, input logic en, input logic b, input logic clr, input logic ack);
    bus.enable    = en;
    bus.serial_in = en ? b : 1'bx;
    bus.clear     = clr;
    bus.data_ack  = ack;
    @(posedge clk);
    model_step(en, b, clr, ack);
    #1;
    check_all(tag);
  endtask

  task automatic send_word(input string tag, input logic [7:0] w, input logic ack_last, input int gap);
    for (int i = W - 1; i >= 0; i--) begin
      cycle(tag, 1'b1, w[i], 1'b0, (i == 0) && ack_last);
      if (i > 0) for (int g = 0; g < gap; g++) cycle(tag, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    bus.enable = 1'b0; bus.serial_in = 1'b0; bus.clear = 1'b0; bus.data_ack = 1'b0;
    model_reset();
    reset = 1'b0;
    #2;
    check_all("reset_async");
    repeat (2) @(posedge clk);
    #1;
    check_all("reset_held");
    reset = 1'b1;
    for (int i = 0; i < 5; i++) cycle("idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // 0xA5: valid only after the 8th bit, then ack keeps the word
    for (int i = W - 1; i >= 1; i--) cycle("a5", 1'b1, 1'(8'hA5 >> i), 1'b0, 1'b0);
    chk("a5_not_yet_valid", 32'(bus.data_valid), 32'd0);
    chk("a5_busy_mid", 32'(bus.busy), 32'd1);
    cycle("a5", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("a5_data", 32'(bus.data_out), 32'hA5);
    chk("a5_valid", 32'(bus.data_valid), 32'd1);
    chk("a5_count", 32'(bus.bit_count), 32'd0);
    cycle("a5_ack", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("a5_ack_valid", 32'(bus.data_valid), 32'd0);
    chk("a5_ack_hold", 32'(bus.data_out), 32'hA5);

    // back-to-back with ack on completion
    send_word("b2b", 8'h3C, 1'b0, 0);
    send_word("b2b", 8'hC3, 1'b1, 0);
    chk("b2b_data", 32'(bus.data_out), 32'hC3);
    chk("b2b_valid", 32'(bus.data_valid), 32'd1);
    chk("b2b_ovr", 32'(bus.overrun), 32'd0);

    // overrun then clear
    cycle("ack", 1'b0, 1'b0, 1'b0, 1'b1);
    send_word("ovr", 8'h11, 1'b0, 0);
    send_word("ovr", 8'h22, 1'b0, 0);
    chk("ovr_data", 32'(bus.data_out), 32'h11);
    chk("ovr_flag", 32'(bus.overrun), 32'd1);
    cycle("clr", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("clr_ovr", 32'(bus.overrun), 32'd0);
    chk("clr_keep", 32'(bus.data_out), 32'h11);
    chk("clr_valid", 32'(bus.data_valid), 32'd1);

    // partial word aborted by clear (bit presented on clear cycle is lost)
    cycle("ack", 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle("part", 1'b1, 1'b1, 1'b0, 1'b0);
    cycle("part_clr", 1'b1, 1'b1, 1'b1, 1'b0);
    chk("part_clr_count", 32'(bus.bit_count), 32'd0);
    send_word("5a", 8'h5A, 1'b0, 0);
    chk("5a_data", 32'(bus.data_out), 32'h5A);
    send_word("81", 8'h81, 1'b1, 1);
    chk("81_data", 32'(bus.data_out), 32'h81);
    chk("81_ovr", 32'(bus.overrun), 32'd0);

    // async reset mid-word while a word is pending
    send_word("66", 8'h66, 1'b1, 0);
    for (int i = 0; i < 5; i++) cycle("ff", 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    check_all("mid_reset");
    #1;
    bus.enable = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    send_word("0f", 8'h0F, 1'b0, 0);
    chk("0f_data", 32'(bus.data_out), 32'h0F);
    chk("0f_valid", 32'(bus.data_valid), 32'd1);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      cycle("rand",
            1'($urandom_range(0, 3) != 0),
            1'($urandom),
            1'($urandom_range(0, 59) == 0),
            1'($urandom_range(0, 4) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
